fa_response_checker: RTL and testbench

Self-checking sequencer for the full-adder block. On a start pulse it drives all eight {Cin, D1, D2} input combinations into a Full_Adder instance. It samples Sum_out/Cout after a programmable settle window, compares them with the arithmetic reference, and reports an error count, the first failing vector and pass/done status. It sits beside the adder in a synthesizable self-test wrapper and is the response-consuming end of the adder's input/output interface.

---
 rtl/fa_response_checker.sv | 106 ++++++++++
 tb/tb_fa_response_checker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_response_checker.sv
// fa_response_checker: walks all eight {Cin, D1, D2} combinations through a
// full adder and scores its Sum_out/Cout responses against the arithmetic sum.
module fa_response_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             D1,
    output logic             D2,
    output logic             Cin,
    input  logic             Sum_out,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0]       SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX       = '1;

    state_t           state;
    logic [2:0]       idx;
    logic [7:0]       settle_cnt;
    logic             exp_sum;
    logic             exp_cout;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign exp_sum  = D1 ^ D2 ^ Cin;
    assign exp_cout = (D1 & D2) | (D1 & Cin) | (D2 & Cin);
    assign mismatch = (Sum_out != exp_sum) || (Cout != exp_cout);

    // Saturating increment, so pass can be derived from this on the last compare.
    assign err_next = (mismatch && (err_count != ERR_MAX))
                    ? err_count + ERR_W'(1)
                    : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= 3'd0;
            settle_cnt       <= 8'd0;
            D1               <= 1'b0;
            D2               <= 1'b0;
            Cin              <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= RUN;
                        idx              <= 3'd0;
                        {Cin, D1, D2}    <= 3'd0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        settle_cnt       <= SETTLE_RELOAD;
                        err_count        <= '0;
                        first_fail_vec   <= 3'd0;
                        first_fail_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else begin
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_vec   <= {Cin, D1, D2};
                            first_fail_valid <= 1'b1;
                        end
                        if (idx != 3'd7) begin
                            idx           <= idx + 3'd1;
                            {Cin, D1, D2} <= idx + 3'd1;
                            settle_cnt    <= SETTLE_RELOAD;
                        end else begin
                            state         <= DONE;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            pass          <= (err_next == '0);
                            {Cin, D1, D2} <= 3'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: three instances with different settle/width
// parameters, each driven by a behavioural adder with selectable faults.
module tb_fa_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Adder modes: 0 golden, 1 Cout stuck-at-0, 2 Sum inverted, 3 per-vector xor masks
    function automatic logic [1:0] fa_dev(input logic a, input logic b, input logic c,
                                          input logic [1:0] mode,
                                          input logic [7:0] ms, input logic [7:0] mc);
        logic [1:0] r;
        logic [2:0] v;
        v = {c, a, b};
        r = 2'(a) + 2'(b) + 2'(c);
        case (mode)
            2'd1: r[1] = 1'b0;
            2'd2: r[0] = ~r[0];
            2'd3: r = r ^ {mc[v], ms[v]};
            default: ;
        endcase
        return r;
    endfunction

    // Score the device over all vectors against plain arithmetic.
    task automatic model(input logic [1:0] mode, input logic [7:0] ms, input logic [7:0] mc,
                         input int max_err, output int err, output int ff, output int ffok);
        err = 0; ff = 0; ffok = 0;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            logic [1:0] ref_r;
            vv = 3'(v);
            ref_r = 2'(vv[0]) + 2'(vv[1]) + 2'(vv[2]);
            if (fa_dev(vv[1], vv[0], vv[2], mode, ms, mc) != ref_r) begin
                if (err < max_err) err++;
                if (ffok == 0) begin
                    ff = v;
                    ffok = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Instance A: SETTLE=1, ERR_W=4
    logic start_a = 1'b0, d1_a, d2_a, cin_a, sum_a, cout_a, busy_a, done_a, pass_a, ffok_a;
    logic [3:0] err_a;
    logic [2:0] ffv_a;
    logic [1:0] mode_a = 2'd0;
    logic [7:0] ms_a = 8'd0, mc_a = 8'd0;
    assign {cout_a, sum_a} = fa_dev(d1_a, d2_a, cin_a, mode_a, ms_a, mc_a);

    fa_response_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .D1(d1_a), .D2(d2_a), .Cin(cin_a), .Sum_out(sum_a), .Cout(cout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffok_a));

    // Instance B: SETTLE=1, ERR_W=2
    logic start_b = 1'b0, d1_b, d2_b, cin_b, sum_b, cout_b, busy_b, done_b, pass_b, ffok_b;
    logic [1:0] err_b;
    logic [2:0] ffv_b;
    logic [1:0] mode_b = 2'd0;
    assign {cout_b, sum_b} = fa_dev(d1_b, d2_b, cin_b, mode_b, 8'd0, 8'd0);

    fa_response_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .D1(d1_b), .D2(d2_b), .Cin(cin_b), .Sum_out(sum_b), .Cout(cout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffok_b));

    // Instance C: SETTLE=3, ERR_W=4
    logic start_c = 1'b0, d1_c, d2_c, cin_c, sum_c, cout_c, busy_c, done_c, pass_c, ffok_c;
    logic [3:0] err_c;
    logic [2:0] ffv_c;
    logic [1:0] mode_c = 2'd0;
    assign {cout_c, sum_c} = fa_dev(d1_c, d2_c, cin_c, mode_c, 8'd0, 8'd0);

    fa_response_checker #(.SETTLE_CYCLES(3), .ERR_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
        .D1(d1_c), .D2(d2_c), .Cin(cin_c), .Sum_out(sum_c), .Cout(cout_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .first_fail_vec(ffv_c), .first_fail_valid(ffok_c));

    function automatic logic [31:0] outs_a();
        return 32'({d1_a, d2_a, cin_a, busy_a, done_a, pass_a, err_a, ffv_a, ffok_a});
    endfunction
    function automatic logic [31:0] outs_b();
        return 32'({d1_b, d2_b, cin_b, busy_b, done_b, pass_b, err_b, ffv_b, ffok_b});
    endfunction
    function automatic logic [31:0] outs_c();
        return 32'({d1_c, d2_c, cin_c, busy_c, done_c, pass_c, err_c, ffv_c, ffok_c});
    endfunction

    // Full run on instance A with the operand walk checked cycle by cycle.
    task automatic run_a(input string tag, input int exp_err, input int exp_ff,
                         input int exp_ffok, input int exp_pass);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_vec"}, 32'({cin_a, d1_a, d2_a}), 32'(k));
            chk({tag, "_busy"}, 32'(busy_a), 32'd1);
            chk({tag, "_done_early"}, 32'(done_a), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(done_a), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_a), 32'd0);
        chk({tag, "_ops_zero"}, 32'({cin_a, d1_a, d2_a}), 32'd0);
        chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
        chk({tag, "_ffv"}, 32'(ffv_a), 32'(exp_ff));
        chk({tag, "_ffok"}, 32'(ffok_a), 32'(exp_ffok));
        chk({tag, "_pass"}, 32'(pass_a), 32'(exp_pass));
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [7:0] ms;
        logic [7:0] mc;
        int         exp_err;
        int         exp_ff;
        int         exp_ffok;
        int         exp_pass;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int e, f, fo, waited;

        tbl[0] = '{"golden", 2'd0, 8'h00, 8'h00, 0, 0, 0, 1};
        tbl[1] = '{"cout0",  2'd1, 8'h00, 8'h00, 4, 3, 1, 0};
        tbl[2] = '{"suminv", 2'd2, 8'h00, 8'h00, 8, 0, 1, 0};
        tbl[3] = '{"lastvec", 2'd3, 8'h80, 8'h00, 1, 7, 1, 0};

        // Reset with random activity on the inputs
        mode_a = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_a = 1'($urandom); start_b = 1'($urandom); start_c = 1'($urandom);
            ms_a = 8'($urandom); mc_a = 8'($urandom);
        end
        chk("rst_a", outs_a(), 32'd0);
        chk("rst_b", outs_b(), 32'd0);
        chk("rst_c", outs_c(), 32'd0);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_a", outs_a(), 32'd0);
            chk("idle_c", outs_c(), 32'd0);
        end

        // Saturation on a 2-bit counter
        mode_b = 2'd2;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        waited = 0;
        while (!done_b && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("b_done_budget", 32'(done_b), 32'd1);
        chk("b_err_sat", 32'(err_b), 32'd3);
        chk("b_pass", 32'(pass_b), 32'd0);
        chk("b_ffv", 32'(ffv_b), 32'd0);
        chk("b_ffok", 32'(ffok_b), 32'd1);

        // SETTLE=3: hold time, ignored start during busy, rerun from DONE
        mode_c = 2'd1;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int n = 0; n < 24; n++) begin
            chk("c_vec", 32'({cin_c, d1_c, d2_c}), 32'(n / 3));
            chk("c_busy", 32'(busy_c), 32'd1);
            chk("c_done_early", 32'(done_c), 32'd0);
            start_c = (n == 4 || n == 13) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start_c = 1'b0;
        chk("c_done", 32'(done_c), 32'd1);
        chk("c_err", 32'(err_c), 32'd4);
        chk("c_ffv", 32'(ffv_c), 32'd3);
        chk("c_pass", 32'(pass_c), 32'd0);
        repeat (3) @(negedge clk);
        chk("c_hold_done", 32'(done_c), 32'd1);
        chk("c_hold_err", 32'(err_c), 32'd4);
        mode_c = 2'd0;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        chk("c_rerun_done_clr", 32'(done_c), 32'd0);
        chk("c_rerun_busy", 32'(busy_c), 32'd1);
        chk("c_rerun_err_clr", 32'(err_c), 32'd0);
        chk("c_rerun_ffok_clr", 32'(ffok_c), 32'd0);
        chk("c_rerun_ffv_clr", 32'(ffv_c), 32'd0);
        repeat (23) @(negedge clk);
        chk("c_rerun_done_early", 32'(done_c), 32'd0);
        @(negedge clk);
        chk("c_rerun_done", 32'(done_c), 32'd1);
        chk("c_rerun_pass", 32'(pass_c), 32'd1);

        // Table of fixed fault patterns on A
        for (int t = 0; t < 4; t++) begin
            mode_a = tbl[t].mode; ms_a = tbl[t].ms; mc_a = tbl[t].mc;
            run_a(tbl[t].name, tbl[t].exp_err, tbl[t].exp_ff, tbl[t].exp_ffok, tbl[t].exp_pass);
        end

        // Random per-vector faults scored by the reference model
        for (int r = 0; r < 8; r++) begin
            mode_a = 2'd3;
            ms_a = 8'($urandom);
            mc_a = (r == 0) ? 8'h00 : 8'($urandom);
            if (r == 1) ms_a = 8'h00;
            if (r == 1) mc_a = 8'h00;
            model(mode_a, ms_a, mc_a, 15, e, f, fo);
            run_a("rand", e, f, fo, (e == 0) ? 1 : 0);
        end

        // Reset while vector 5 is driven
        mode_a = 2'd1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_vec5", 32'({cin_a, d1_a, d2_a}), 32'd5);
        chk("mid_busy", 32'(busy_a), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_a", outs_a(), 32'd0);
        chk("mid_rst_c", outs_c(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode_a = 2'd0;
        run_a("post_rst", 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
